// File: rtl/ui_pkg.sv
// Shared button indices, cell state encoding and default timing constants.
// Used by button_conditioner and user_interface.
package ui_pkg;

  localparam int NUM_BTN_DEF = 6;

  localparam int BTN_ENTER = 0;
  localparam int BTN_UP    = 1;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_LEFT  = 3;
  localparam int BTN_RIGHT = 4;
  localparam int BTN_MENU  = 5;

  // 10 ms, 500 ms and 100 ms at 27 MHz
  localparam int DEF_DEBOUNCE_CYCLES = 270000;
  localparam int DEF_REPEAT_DELAY    = 13500000;
  localparam int DEF_REPEAT_PERIOD   = 2700000;
  localparam logic [5:0] DEF_REPEAT_MASK = 6'b000110;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } cell_state_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/button_conditioner_debounce_cell.sv
// Single-button synchronizer, debouncer, press/release pulses and hold FSM.
// Auto-repeat logic is present only when BUTTON_AUTOREPEAT_EN is defined.
module debounce_cell
  import ui_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef BUTTON_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter bit REPEAT_EN     = 1'b0
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_n,
  output logic level,
  output logic press,
  output logic rel
);

  localparam int CW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          s;
  logic          flip;
  logic          rise;
  logic          fall;
  logic          rep;

  cell_state_t state_q;
  cell_state_t state_d;

  assign s    = ~sync_q[1];
  assign flip = (s != level) && (cnt_q == CMAX);
  assign rise = flip & ~level;
  assign fall = flip & level;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
      level  <= 1'b0;
      press  <= 1'b0;
      rel    <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw_n};
      if (s == level || flip)
        cnt_q <= '0;
      else if (cnt_q != CMAX)
        cnt_q <= cnt_q + 1'b1;
      level <= level ^ flip;
      press <= rise | rep;
      rel   <= fall;
    end
  end

`ifdef BUTTON_AUTOREPEAT_EN
  localparam int HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                        REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW = cnt_w(HMAX);
  localparam logic [HW-1:0] HDLY = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] HPER = HW'(REPEAT_PERIOD - 1);

  logic [HW-1:0] hcnt_q;
  logic [HW-1:0] hcnt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      hcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    rep     = 1'b0;
    unique case (state_q)
      IDLE: begin
        hcnt_d = '0;
        if (rise) state_d = HELD;
      end
      HELD: begin
        if (fall) begin
          state_d = IDLE;
          hcnt_d  = '0;
        end else if (REPEAT_EN) begin
          if (hcnt_q == HDLY) begin
            state_d = REPEAT;
            hcnt_d  = '0;
            rep     = 1'b1;
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end
      end
      REPEAT: begin
        if (fall) begin
          state_d = IDLE;
          hcnt_d  = '0;
        end else if (hcnt_q == HPER) begin
          hcnt_d = '0;
          rep    = 1'b1;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        hcnt_d  = '0;
      end
    endcase
  end
`else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    rep     = 1'b0;
    unique case (state_q)
      IDLE:    if (rise) state_d = HELD;
      HELD:    if (fall) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
`endif

endmodule

// File: rtl/button_conditioner.sv
// Debounces the labkit pushbuttons into levels and press/release pulses.
// Define BUTTON_AUTOREPEAT_EN to enable auto-repeat on REPEAT_MASK keys.
module button_conditioner
  import ui_pkg::*;
#(
  parameter int NUM_BTN         = NUM_BTN_DEF,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK = NUM_BTN'(DEF_REPEAT_MASK)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw_n,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic               any_press
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_cell
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef BUTTON_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
      .REPEAT_EN      (REPEAT_MASK[i])
`endif
    ) u_cell (
      .clk  (clk),
      .reset(reset),
      .raw_n(btn_raw_n[i]),
      .level(btn_level[i]),
      .press(btn_press[i]),
      .rel  (btn_release[i])
    );
  end

  assign any_press = |btn_press;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short timing parameters.
// Build with or without BUTTON_AUTOREPEAT_EN.
module tb_button_conditioner;

  localparam int N = 6;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] btn_raw_n = '1;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;
  logic         any_press;

  int checks = 0;
  int errors = 0;

  button_conditioner #(
    .NUM_BTN        (N),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3),
    .REPEAT_MASK    (6'b000110)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw_n  (btn_raw_n),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .any_press  (any_press)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] raw;
    int           n;
    logic [N-1:0] lvl;
    logic [N-1:0] prs;
    logic [N-1:0] rls;
  } vec_t;

  vec_t tbl[$];

`ifdef BUTTON_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [N-1:0] lvl,
                     input logic [N-1:0] prs, input logic [N-1:0] rls);
    logic [3*N:0] got;
    logic [3*N:0] exp;
    got = {btn_level, btn_press, btn_release, any_press};
    exp = {lvl, prs, rls, |prs};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t lvl/prs/rel/any got %b_%b_%b_%b want %b_%b_%b_%b",
               nm, $time, btn_level, btn_press, btn_release, any_press,
               lvl, prs, rls, |prs);
    end
  endtask

  task automatic hold_down(input int b, input string nm);
    bit p;
    for (int k = 1; k <= 48; k++) begin
      btn_raw_n = '1;
      if (k <= 40) btn_raw_n[b] = 1'b0;
      step();
      p = (k == 6) ||
          (AR && b == 2 && k >= 16 && k < 46 && (k - 16) % 3 == 0);
      chk(nm, N'((k >= 6 && k < 46) ? (1 << b) : 0),
          N'(p ? (1 << b) : 0), N'((k == 46) ? (1 << b) : 0));
    end
  endtask

  initial begin
    // reset held low with all buttons released
    for (int k = 0; k < 3; k++) begin
      step();
      chk("reset_idle", '0, '0, '0);
    end
    reset = 1'b1;

    // clean press of up, release, then left+right together
    tbl.push_back('{6'h3d, 5, 6'h00, 6'h00, 6'h00});
    tbl.push_back('{6'h3d, 1, 6'h02, 6'h02, 6'h00});
    tbl.push_back('{6'h3d, 3, 6'h02, 6'h00, 6'h00});
    tbl.push_back('{6'h3f, 5, 6'h02, 6'h00, 6'h00});
    tbl.push_back('{6'h3f, 1, 6'h00, 6'h00, 6'h02});
    tbl.push_back('{6'h3f, 2, 6'h00, 6'h00, 6'h00});
    tbl.push_back('{6'h27, 5, 6'h00, 6'h00, 6'h00});
    tbl.push_back('{6'h27, 1, 6'h18, 6'h18, 6'h00});
    tbl.push_back('{6'h27, 2, 6'h18, 6'h00, 6'h00});
    tbl.push_back('{6'h3f, 5, 6'h18, 6'h00, 6'h00});
    tbl.push_back('{6'h3f, 1, 6'h00, 6'h00, 6'h18});
    tbl.push_back('{6'h3f, 2, 6'h00, 6'h00, 6'h00});

    foreach (tbl[i]) begin
      btn_raw_n = tbl[i].raw;
      for (int k = 0; k < tbl[i].n; k++) begin
        step();
        chk($sformatf("vec%0d", i), tbl[i].lvl, tbl[i].prs, tbl[i].rls);
      end
    end

    // enter bounces every 2 cycles, never settling long enough
    for (int i = 0; i < 10; i++) begin
      btn_raw_n = 6'h3f;
      btn_raw_n[0] = i[0];
      repeat (2) begin
        step();
        chk("bounce", '0, '0, '0);
      end
    end
    btn_raw_n = 6'h3f;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("bounce_tail", '0, '0, '0);
    end

    hold_down(2, "hold_down");
    hold_down(0, "hold_enter");

    // reset while down is deep in its hold
    btn_raw_n = 6'h3b;
    repeat (20) step();
    reset = 1'b0;
    #1;
    chk("reset_async", '0, '0, '0);
    step();
    chk("reset_hold", '0, '0, '0);
    step();
    reset = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("repress", N'((k == 6) ? 4 : 0), N'((k == 6) ? 4 : 0), '0);
    end
    btn_raw_n = 6'h3f;
    repeat (10) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Front-end stage directly upstream of user_interface.
- Takes the raw, bouncing, asynchronous labkit pushbuttons (enter, up, down, left, right, reset-menu key) and produces two signals per button for the menu/call-state FSM:
  - a clean debounced level;
  - a single-cycle press pulse.
- Optional auto-repeat on held navigation keys lets the user scroll through menu items and digits.

Parameters:
- NUM_BTN, 6, number of conditioned buttons; bit index order is defined in ui_pkg.
- DEBOUNCE_CYCLES, 270000, cycles a synchronized input must hold a new value before the debounced level changes (10 ms at 27 MHz).
- REPEAT_DELAY, 13500000, hold cycles before the first auto-repeat pulse (500 ms).
- REPEAT_PERIOD, 2700000, cycles between later auto-repeat pulses (100 ms).
- REPEAT_MASK, 6'b000110, buttons allowed to auto-repeat (up, down).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- btn_raw_n  in  NUM_BTN  raw pushbuttons, active-low, asynchronous to clk.
- btn_level  out  NUM_BTN  debounced level, 1 = held.
- btn_press  out  NUM_BTN  one-cycle pulse on each accepted press or repeat.
- btn_release  out  NUM_BTN  one-cycle pulse on debounced release.
- any_press  out  1  OR of btn_press, for UI wake/backlight.

Behaviour:
- Reset (reset low, asynchronous):
  - sync flops forced to 1 (released);
  - all counters cleared; all outputs 0; every cell in IDLE.
  - Reset deasserts asynchronously into the flops; the first sample is taken on the next clk edge.
- Synchronizer: two flops per bit on btn_raw_n. Inverted output s = pressed. Latency from raw edge to s is 2 cycles.
- Debounce, per cell:
  - cnt counts while s != btn_level and clears whenever s == btn_level.
  - When cnt reaches DEBOUNCE_CYCLES-1 and s still differs, btn_level toggles on the next edge and cnt clears.
  - Total latency from raw edge to btn_level: DEBOUNCE_CYCLES+2 cycles.
  - Any glitch shorter than DEBOUNCE_CYCLES restarts the count; btn_level does not change.
  - cnt width is $clog2(DEBOUNCE_CYCLES) and saturates, never wraps.
- Edge outputs:
  - btn_press[i] = 1 for exactly the cycle in which btn_level[i] rises 0->1.
  - btn_release[i] = 1 for exactly the cycle in which btn_level[i] falls.
  - Press and release are never both high for one bit in the same cycle.
- Per-cell FSM: IDLE -> HELD on the debounced rise. HELD -> REPEAT (feature only). Any state -> IDLE on the debounced fall.
- Simultaneous buttons: cells are fully independent. Several btn_press bits may pulse in the same cycle; user_interface resolves priority.
- Reset mid-debounce: the pending transition is discarded and the cell restarts from released.

Optional Feature:
- Macro: BUTTON_AUTOREPEAT_EN.
- Defined:
  - Cells with REPEAT_MASK[i]=1 run a hold counter in HELD. After REPEAT_DELAY cycles they enter REPEAT and pulse btn_press once.
  - In REPEAT, btn_press pulses every REPEAT_PERIOD cycles until release.
  - Release in any state returns to IDLE, clears the hold counter and emits btn_release.
  - Counter width is $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)).
- Undefined:
  - No hold counter or REPEAT state exists; HELD transitions only to IDLE.
  - Exactly one btn_press per physical press.
  - REPEAT_DELAY, REPEAT_PERIOD and REPEAT_MASK are ignored.

Decomposition:
- ui_pkg holds:
  - button index constants BTN_ENTER=0, BTN_UP=1, BTN_DOWN=2, BTN_LEFT=3, BTN_RIGHT=4, BTN_MENU=5;
  - the cell state encoding IDLE=2'd0, HELD=2'd1, REPEAT=2'd2;
  - the default cycle-count constants shared with user_interface.
- One sub-module, debounce_cell: synchronizer, debounce counter, FSM and edge pulses for a single bit.
  - Instantiated NUM_BTN times by a generate loop.
  - Receives its REPEAT_MASK bit as a parameter.
- Top level: generate loop plus any_press OR.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3):
- Reset then idle: hold reset low 3 cycles, all raw=1 -> all outputs 0; any_press=0 throughout.
- Clean press: up raw goes 0 at cycle 0 and holds -> btn_level[1]=1 at cycle 6; btn_press[1] single pulse at cycle 6; btn_release stays 0.
- Bounce rejection: enter raw toggles 0/1 every 2 cycles for 20 cycles, then stays 1 -> btn_level[0] stays 0; no press pulses.
- Simultaneous presses: left and right drop in the same cycle -> btn_press[3] and btn_press[4] pulse in the same cycle; any_press high exactly 1 cycle.
- Auto-repeat (macro defined): hold down 40 cycles:
  - btn_press[2] pulses at 6, 16, 19, 22, 25, …;
  - single btn_release[2] pulse 6 cycles after raw returns to 1.
  - Same stimulus on enter gives one pulse only.
  - Macro undefined: down gives one pulse only.
- Reset mid-operation: assert reset while down is in REPEAT -> outputs 0 immediately; after deassert with raw still 0, a fresh press pulse arrives DEBOUNCE_CYCLES+2 cycles later.
